// File: rtl/letter_entry.sv
// letter_entry: collects four debounced letter entries into a guess word and
// hands it to the game core with a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   switch_input[9:0] [9:3] one-hot letter column (bit9 = column 0), [2:0] group code
//   enter             raw push-button level (idle/released = 1)
//   guess_word[19:0]  four 5-bit letter indices, letter 0 in [4:0]
//   guess_valid       guess_word holds a complete guess
//   guess_ready       downstream accepts the guess
//   letter_count[2:0] letters stored, 0..4
//   cur_letter[4:0]   combinational decode of switch_input, 31 when invalid
//   err_pulse         one-cycle pulse when an entry is rejected
//
// Build option: define LETTER_ENTRY_BACKSPACE_EN so that an entry with
// switch_input == 0 deletes the last stored letter instead of being rejected.
module letter_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  switch_input,
  input  logic        enter,
  output logic [19:0] guess_word,
  output logic        guess_valid,
  input  logic        guess_ready,
  output logic [2:0]  letter_count,
  output logic [4:0]  cur_letter,
  output logic        err_pulse
);

  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

`ifdef LETTER_ENTRY_BACKSPACE_EN
  localparam bit BACKSPACE_EN = 1'b1;
`else
  localparam bit BACKSPACE_EN = 1'b0;
`endif

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic               deb_q, deb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        word_q, word_d;
  logic [2:0]         count_q, count_d;
  logic               err_q, err_d;
  logic               entry_event;

  logic [2:0]         col;
  logic [1:0]         grp;
  logic               grp_ok;
  logic               col_ok;
  logic [4:0]         idx;
  logic               cur_valid;

  // Letter decode: index = 7*group + column, legal only for a single column bit
  always_comb begin
    col = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (switch_input[9-i]) col = 3'(i);
    end
    col_ok = $onehot(switch_input[9:3]);
    grp    = 2'd0;
    grp_ok = 1'b1;
    case (switch_input[2:0])
      3'b000:  grp = 2'd0;
      3'b001:  grp = 2'd1;
      3'b010:  grp = 2'd2;
      3'b100:  grp = 2'd3;
      default: grp_ok = 1'b0;
    endcase
    idx        = 5'(grp) * 5'd7 + 5'(col);
    cur_valid  = col_ok && grp_ok && (idx <= 5'd25);
    cur_letter = cur_valid ? idx : 5'd31;
  end

  // Synchronizer shift and debouncer: level follows only after a full stable run
  always_comb begin
    sync_d = {sync_q[0], enter};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // One event per debounced 1->0 transition, acted on at the edge it occurs
  assign entry_event = deb_q && !deb_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (entry_event && cur_valid && count_q == 3'd3) state_d = PRESENT;
      PRESENT: if (guess_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Storage and error logic per state
  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (entry_event) begin
          if (BACKSPACE_EN && switch_input == 10'd0) begin
            if (count_q == 3'd0) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (count_q == 3'(i + 1)) word_d[SLOT_W*i +: SLOT_W] = '0;
              end
              count_d = count_q - 3'd1;
            end
          end else if (cur_valid) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (count_q == 3'(i)) word_d[SLOT_W*i +: SLOT_W] = cur_letter;
            end
            count_d = count_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRESENT: begin
        // Events are ignored here; only the handshake changes storage
        if (guess_ready) begin
          word_d  = '0;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign guess_word   = word_q;
  assign guess_valid  = (state_q == PRESENT);
  assign letter_count = count_q;
  assign err_pulse    = err_q;

endmodule

// File: tb/tb_letter_entry.sv
// Bench for letter_entry with DEBOUNCE_CYCLES = 4: decode table, entry table,
// then directed handshake, bounce, reset and deletion sequences.
module tb_letter_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  switch_input;
  logic        enter;
  logic [19:0] guess_word;
  logic        guess_valid;
  logic        guess_ready;
  logic [2:0]  letter_count;
  logic [4:0]  cur_letter;
  logic        err_pulse;

  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;

  localparam logic [9:0] SW_A = 10'b1000000000;
  localparam logic [9:0] SW_B = 10'b0100000000;
  localparam logic [9:0] SW_C = 10'b0010000000;
  localparam logic [9:0] SW_I = 10'b0100000001;
  localparam logic [9:0] SW_T = 10'b0000010010;
  localparam logic [9:0] SW_S = 10'b0000100010;
  localparam logic [9:0] SW_G3C5 = 10'b0000010100;
  localparam logic [9:0] SW_TWO  = 10'b1100000000;

  letter_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switch_input (switch_input),
    .enter        (enter),
    .guess_word   (guess_word),
    .guess_valid  (guess_valid),
    .guess_ready  (guess_ready),
    .letter_count (letter_count),
    .cur_letter   (cur_letter),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  // Count error-pulse cycles while out of reset
  always @(negedge clk) begin
    if (rst_n && err_pulse) err_seen++;
  end

  typedef struct {
    logic [9:0] sw;
    logic [4:0] letter;
  } dec_vec_t;

  typedef struct {
    logic [9:0]  sw;
    logic [2:0]  count;
    logic [19:0] word;
    logic        valid;
    int          errs;
  } ent_vec_t;

  dec_vec_t dec_tab[10];
  ent_vec_t ent_tab[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press (drive low), hold past debounce, release and let it settle
  task automatic enter_code(input logic [9:0] sw);
    switch_input = sw;
    enter = 1'b0;
    tick(10);
    enter = 1'b1;
    tick(10);
  endtask

  initial begin
    dec_tab[0] = '{SW_A, 5'd0};
    dec_tab[1] = '{SW_B, 5'd1};
    dec_tab[2] = '{SW_I, 5'd8};
    dec_tab[3] = '{SW_T, 5'd19};
    dec_tab[4] = '{SW_S, 5'd18};
    dec_tab[5] = '{10'b0000100100, 5'd25};
    dec_tab[6] = '{SW_G3C5, 5'd31};
    dec_tab[7] = '{SW_TWO, 5'd31};
    dec_tab[8] = '{10'b0000000000, 5'd31};
    dec_tab[9] = '{10'b1000000011, 5'd31};

    ent_tab[0] = '{SW_B,    3'd1, {15'd0, 5'd1},              1'b0, 0};
    ent_tab[1] = '{SW_G3C5, 3'd1, {15'd0, 5'd1},              1'b0, 1};
    ent_tab[2] = '{SW_TWO,  3'd1, {15'd0, 5'd1},              1'b0, 2};
    ent_tab[3] = '{SW_I,    3'd2, {10'd0, 5'd8, 5'd1},        1'b0, 2};
    ent_tab[4] = '{SW_T,    3'd3, {5'd0, 5'd19, 5'd8, 5'd1},  1'b0, 2};
    ent_tab[5] = '{SW_S,    3'd4, {5'd18, 5'd19, 5'd8, 5'd1}, 1'b1, 2};

    rst_n = 1'b0;
    enter = 1'b1;
    switch_input = '0;
    guess_ready = 1'b0;
    tick(2);
    chk("reset_count", 32'(letter_count), 32'd0);
    chk("reset_word",  32'(guess_word),   32'd0);
    chk("reset_valid", 32'(guess_valid),  32'd0);
    chk("reset_err",   32'(err_pulse),    32'd0);
    rst_n = 1'b1;
    tick(3);

    foreach (dec_tab[i]) begin
      switch_input = dec_tab[i].sw;
      #1;
      chk($sformatf("decode[%0d]", i), 32'(cur_letter), 32'(dec_tab[i].letter));
    end
    tick(1);

    foreach (ent_tab[i]) begin
      enter_code(ent_tab[i].sw);
      chk($sformatf("entry_count[%0d]", i), 32'(letter_count), 32'(ent_tab[i].count));
      chk($sformatf("entry_word[%0d]", i),  32'(guess_word),   32'(ent_tab[i].word));
      chk($sformatf("entry_valid[%0d]", i), 32'(guess_valid),  32'(ent_tab[i].valid));
      chk($sformatf("entry_errs[%0d]", i),  32'(err_seen),     32'(ent_tab[i].errs));
    end

    // Guess held while ready stays low; events in PRESENT are discarded
    tick(10);
    chk("hold_word",  32'(guess_word),  32'({5'd18, 5'd19, 5'd8, 5'd1}));
    chk("hold_valid", 32'(guess_valid), 32'd1);
    enter_code(SW_TWO);
    enter_code(SW_A);
    chk("present_errs",  32'(err_seen),     32'd2);
    chk("present_word",  32'(guess_word),   32'({5'd18, 5'd19, 5'd8, 5'd1}));
    chk("present_count", 32'(letter_count), 32'd4);

    // Handshake clears the guess
    guess_ready = 1'b1;
    tick(1);
    guess_ready = 1'b0;
    chk("hs_valid", 32'(guess_valid),  32'd0);
    chk("hs_count", 32'(letter_count), 32'd0);
    chk("hs_word",  32'(guess_word),   32'd0);

    // Ready while no guess is pending does nothing
    guess_ready = 1'b1;
    tick(3);
    guess_ready = 1'b0;
    chk("idle_ready_valid", 32'(guess_valid),  32'd0);
    chk("idle_ready_count", 32'(letter_count), 32'd0);

    // Bouncing press yields a single entry
    switch_input = SW_C;
    enter = 1'b0; tick(2);
    enter = 1'b1; tick(2);
    enter = 1'b0; tick(10);
    enter = 1'b1; tick(10);
    chk("bounce_count", 32'(letter_count), 32'd1);
    chk("bounce_word",  32'(guess_word),   32'd2);

    // Reset in the middle of a debounce discards everything
    enter_code(SW_A);
    chk("pre_rst_count", 32'(letter_count), 32'd2);
    switch_input = SW_B;
    enter = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(letter_count), 32'd0);
    chk("mid_rst_word",  32'(guess_word),   32'd0);
    chk("mid_rst_valid", 32'(guess_valid),  32'd0);
    chk("mid_rst_err",   32'(err_pulse),    32'd0);
    enter = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_count", 32'(letter_count), 32'd0);
    enter_code(SW_B);
    chk("post_rst_slot0_count", 32'(letter_count), 32'd1);
    chk("post_rst_slot0_word",  32'(guess_word),   32'd1);

    // All-zero entry: deletion when enabled, rejection otherwise
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    enter_code(SW_A);
    enter_code(SW_C);
    chk("ac_count", 32'(letter_count), 32'd2);
    chk("ac_word",  32'(guess_word),   32'({10'd0, 5'd2, 5'd0}));
    enter_code(10'd0);
`ifdef LETTER_ENTRY_BACKSPACE_EN
    chk("bs_count", 32'(letter_count), 32'd1);
    chk("bs_word",  32'(guess_word),   32'd0);
    chk("bs_errs",  32'(err_seen),     32'd2);
    enter_code(10'd0);
    chk("bs2_count", 32'(letter_count), 32'd0);
    enter_code(10'd0);
    chk("bs_empty_errs",  32'(err_seen),     32'd3);
    chk("bs_empty_count", 32'(letter_count), 32'd0);
`else
    chk("zero_count", 32'(letter_count), 32'd2);
    chk("zero_word",  32'(guess_word),   32'({10'd0, 5'd2, 5'd0}));
    chk("zero_errs",  32'(err_seen),     32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
